// File: rtl/intc_cpu_responder.sv
// rtl/intc_cpu_responder.sv - CPU-side IRQ/IACK responder: takes interrupts at
// instruction boundaries, redirects fetch to the ISR and back on mret.
module intc_cpu_responder #(
  parameter int   IACK_CYCLES = 1,
  parameter logic EN_RESET    = 1'b1,
  parameter int   CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             irq,
  input  logic [31:0]      isr_addr,
  input  logic             instr_retire,
  input  logic [31:0]      pc_next,
  input  logic             mret,
  input  logic             en_we,
  input  logic             en_wdata,
  output logic             iack,
  output logic             pc_redirect,
  output logic [31:0]      redirect_addr,
  output logic [31:0]      epc,
  output logic             in_isr,
  output logic             int_enable,
  output logic [CNT_W-1:0] irq_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK,
    S_VECTOR,
    S_IN_ISR,
    S_RETURN
  } state_e;

  localparam logic [3:0] PULSE_INIT = 4'(IACK_CYCLES - 1);

  state_e            state_q, state_d;
  logic              iack_q, iack_d;
  logic              pc_redirect_q, pc_redirect_d;
  logic [31:0]       redirect_addr_q, redirect_addr_d;
  logic [31:0]       epc_q, epc_d;
  logic              in_isr_q, in_isr_d;
  logic              int_enable_q, int_enable_d;
  logic [CNT_W-1:0]  irq_count_q, irq_count_d;
  logic [31:0]       vector_q, vector_d;
  logic [3:0]        pulse_cnt_q, pulse_cnt_d;

  logic take_irq;
  logic mret_retire;
  logic ack_done;

  // The enable used to qualify a take is the registered one; a same-cycle
  // en_we only lands in int_enable_q at this edge.
  assign take_irq    = irq & int_enable_q & instr_retire & ~mret;
  assign mret_retire = instr_retire & mret;
  assign ack_done    = (pulse_cnt_q == 4'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (take_irq) state_d = S_ACK;
      S_ACK:    if (ack_done) state_d = S_VECTOR;
      S_VECTOR: state_d = S_IN_ISR;
      S_IN_ISR: if (mret_retire) state_d = S_RETURN;
      S_RETURN: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    iack_d          = iack_q;
    pc_redirect_d   = pc_redirect_q;
    redirect_addr_d = redirect_addr_q;
    epc_d           = epc_q;
    in_isr_d        = in_isr_q;
    int_enable_d    = int_enable_q;
    irq_count_d     = irq_count_q;
    vector_d        = vector_q;
    pulse_cnt_d     = pulse_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (en_we) int_enable_d = en_wdata;
        if (take_irq) begin
          epc_d       = pc_next;
          vector_d    = isr_addr;
          iack_d      = 1'b1;
          pulse_cnt_d = PULSE_INIT;
        end
      end
      S_ACK: begin
        if (ack_done) begin
          iack_d          = 1'b0;
          pc_redirect_d   = 1'b1;
          redirect_addr_d = vector_q;
        end else begin
          pulse_cnt_d = pulse_cnt_q - 4'd1;
        end
      end
      S_VECTOR: begin
        pc_redirect_d = 1'b0;
        in_isr_d      = 1'b1;
        int_enable_d  = 1'b0;
        if (irq_count_q != {CNT_W{1'b1}}) irq_count_d = irq_count_q + CNT_W'(1);
      end
      S_IN_ISR: begin
        if (en_we) int_enable_d = en_wdata;
        if (mret_retire) begin
          pc_redirect_d   = 1'b1;
          redirect_addr_d = epc_q;
        end
      end
      S_RETURN: begin
        pc_redirect_d = 1'b0;
        in_isr_d      = 1'b0;
        int_enable_d  = 1'b1;
      end
      default: begin
        iack_d        = 1'b0;
        pc_redirect_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iack_q          <= 1'b0;
      pc_redirect_q   <= 1'b0;
      redirect_addr_q <= 32'd0;
      epc_q           <= 32'd0;
      in_isr_q        <= 1'b0;
      int_enable_q    <= EN_RESET;
      irq_count_q     <= '0;
      vector_q        <= 32'd0;
      pulse_cnt_q     <= 4'd0;
    end else begin
      iack_q          <= iack_d;
      pc_redirect_q   <= pc_redirect_d;
      redirect_addr_q <= redirect_addr_d;
      epc_q           <= epc_d;
      in_isr_q        <= in_isr_d;
      int_enable_q    <= int_enable_d;
      irq_count_q     <= irq_count_d;
      vector_q        <= vector_d;
      pulse_cnt_q     <= pulse_cnt_d;
    end
  end

  assign iack          = iack_q;
  assign pc_redirect   = pc_redirect_q;
  assign redirect_addr = redirect_addr_q;
  assign epc           = epc_q;
  assign in_isr        = in_isr_q;
  assign int_enable    = int_enable_q;
  assign irq_count     = irq_count_q;

endmodule

// File: tb/tb_intc_cpu_responder.sv
// tb/tb_intc_cpu_responder.sv - directed vector bench for intc_cpu_responder
// across three parameterisations sharing one stimulus bus.
module tb_intc_cpu_responder;

  typedef struct {
    string       name;
    logic        irq;
    logic [31:0] addr;
    logic        ret;
    logic [31:0] pcn;
    logic        mr;
    logic        we;
    logic        wd;
    logic        e_iack;
    logic        e_red;
    logic [31:0] e_ra;
    logic [31:0] e_epc;
    logic        e_in;
    logic        e_en;
    logic [15:0] e_cnt;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        irq;
  logic [31:0] isr_addr;
  logic        instr_retire;
  logic [31:0] pc_next;
  logic        mret;
  logic        en_we;
  logic        en_wdata;

  logic        o1_iack, o1_red, o1_in, o1_en;
  logic [31:0] o1_ra, o1_epc;
  logic [15:0] o1_cnt;
  logic        o3_iack, o3_red, o3_in, o3_en;
  logic [31:0] o3_ra, o3_epc;
  logic [1:0]  o3_cnt;
  logic        o4_iack, o4_red, o4_in, o4_en;
  logic [31:0] o4_ra, o4_epc;
  logic [15:0] o4_cnt;

  int n_vec;
  int n_fail;

  intc_cpu_responder #(.IACK_CYCLES(1), .EN_RESET(1'b1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .irq(irq), .isr_addr(isr_addr), .instr_retire(instr_retire),
    .pc_next(pc_next), .mret(mret), .en_we(en_we), .en_wdata(en_wdata),
    .iack(o1_iack), .pc_redirect(o1_red), .redirect_addr(o1_ra), .epc(o1_epc),
    .in_isr(o1_in), .int_enable(o1_en), .irq_count(o1_cnt)
  );

  intc_cpu_responder #(.IACK_CYCLES(3), .EN_RESET(1'b1), .CNT_W(2)) dut3 (
    .clk(clk), .rst(rst), .irq(irq), .isr_addr(isr_addr), .instr_retire(instr_retire),
    .pc_next(pc_next), .mret(mret), .en_we(en_we), .en_wdata(en_wdata),
    .iack(o3_iack), .pc_redirect(o3_red), .redirect_addr(o3_ra), .epc(o3_epc),
    .in_isr(o3_in), .int_enable(o3_en), .irq_count(o3_cnt)
  );

  intc_cpu_responder #(.IACK_CYCLES(4), .EN_RESET(1'b0), .CNT_W(16)) dut4 (
    .clk(clk), .rst(rst), .irq(irq), .isr_addr(isr_addr), .instr_retire(instr_retire),
    .pc_next(pc_next), .mret(mret), .en_we(en_we), .en_wdata(en_wdata),
    .iack(o4_iack), .pc_redirect(o4_red), .redirect_addr(o4_ra), .epc(o4_epc),
    .in_isr(o4_in), .int_enable(o4_en), .irq_count(o4_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input string n, input logic i, input logic [31:0] a,
                              input logic r, input logic [31:0] p, input logic m,
                              input logic w, input logic d, input logic ei,
                              input logic er, input logic [31:0] era,
                              input logic [31:0] eepc, input logic ein,
                              input logic een, input logic [15:0] ecnt);
    vec_t v;
    v.name = n; v.irq = i; v.addr = a; v.ret = r; v.pcn = p; v.mr = m;
    v.we = w; v.wd = d; v.e_iack = ei; v.e_red = er; v.e_ra = era;
    v.e_epc = eepc; v.e_in = ein; v.e_en = een; v.e_cnt = ecnt;
    return v;
  endfunction

  task automatic check(input int sel, input vec_t v);
    logic [83:0] act;
    logic [83:0] exp;
    case (sel)
      1:       act = {o1_iack, o1_red, o1_ra, o1_epc, o1_in, o1_en, o1_cnt};
      3:       act = {o3_iack, o3_red, o3_ra, o3_epc, o3_in, o3_en, 14'd0, o3_cnt};
      default: act = {o4_iack, o4_red, o4_ra, o4_epc, o4_in, o4_en, o4_cnt};
    endcase
    exp = {v.e_iack, v.e_red, v.e_ra, v.e_epc, v.e_in, v.e_en, v.e_cnt};
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got iack=%0b red=%0b ra=%h epc=%h in_isr=%0b en=%0b cnt=%0d, want iack=%0b red=%0b ra=%h epc=%h in_isr=%0b en=%0b cnt=%0d",
               v.name, act[83], act[82], act[81:50], act[49:18], act[17], act[16], act[15:0],
               v.e_iack, v.e_red, v.e_ra, v.e_epc, v.e_in, v.e_en, v.e_cnt);
    end
  endtask

  task automatic step(input int sel, input vec_t v);
    @(negedge clk);
    irq = v.irq; isr_addr = v.addr; instr_retire = v.ret; pc_next = v.pcn;
    mret = v.mr; en_we = v.we; en_wdata = v.wd;
    @(posedge clk);
    #1;
    check(sel, v);
  endtask

  task automatic do_reset(input int sel, input logic en_rst);
    @(negedge clk);
    rst = 1'b0;
    irq = 0; isr_addr = 0; instr_retire = 0; pc_next = 0; mret = 0; en_we = 0; en_wdata = 0;
    @(posedge clk);
    #1;
    check(sel, mk("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, en_rst, 0));
    @(negedge clk);
    rst = 1'b1;
  endtask

  vec_t tbl[9];

  initial begin
    logic [31:0] pc, a, pra;
    logic [15:0] cp, c;
    n_vec = 0; n_fail = 0;
    rst = 1'b0;
    irq = 0; isr_addr = 0; instr_retire = 0; pc_next = 0; mret = 0; en_we = 0; en_wdata = 0;

    // IACK_CYCLES=1: basic take/return and stray mret
    tbl[0] = mk("b_idle",     0, 0,         0, 0,         0, 0, 0, 0, 0, 0,         0,         0, 1, 0);
    tbl[1] = mk("b_take",     1, 32'h200,   1, 32'h104,   0, 0, 0, 1, 0, 0,         32'h104,   0, 1, 0);
    tbl[2] = mk("b_redir",    0, 0,         0, 0,         0, 0, 0, 0, 1, 32'h200,   32'h104,   0, 1, 0);
    tbl[3] = mk("b_vector",   0, 0,         0, 0,         0, 0, 0, 0, 0, 32'h200,   32'h104,   1, 0, 1);
    tbl[4] = mk("b_nonest",   1, 32'h600,   1, 32'h500,   0, 0, 0, 0, 0, 32'h200,   32'h104,   1, 0, 1);
    tbl[5] = mk("b_mret_nr",  0, 0,         0, 0,         1, 0, 0, 0, 0, 32'h200,   32'h104,   1, 0, 1);
    tbl[6] = mk("b_mret",     0, 0,         1, 0,         1, 0, 0, 0, 1, 32'h104,   32'h104,   1, 0, 1);
    tbl[7] = mk("b_return",   0, 0,         0, 0,         0, 0, 0, 0, 0, 32'h104,   32'h104,   0, 1, 1);
    tbl[8] = mk("b_idle_mret",1, 32'h600,   1, 32'h700,   1, 0, 0, 0, 0, 32'h104,   32'h104,   0, 1, 1);

    do_reset(1, 1'b1);
    for (int i = 0; i < 9; i++) step(1, tbl[i]);

    step(1, mk("m_disable", 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h104, 32'h104, 0, 0, 1));
    for (int i = 0; i < 10; i++)
      step(1, mk("m_masked", 1, 32'h600, 1, 32'h208, 0, 0, 0, 0, 0, 32'h104, 32'h104, 0, 0, 1));
    step(1, mk("m_enable",  1, 32'h600, 0, 0,       0, 1, 1, 0, 0, 32'h104, 32'h104, 0, 1, 1));
    step(1, mk("m_take",    1, 32'h600, 1, 32'h20C, 0, 0, 0, 1, 0, 32'h104, 32'h20C, 0, 1, 1));
    step(1, mk("m_ack_we",  0, 0,       0, 0,       0, 1, 0, 0, 1, 32'h600, 32'h20C, 0, 1, 1));
    step(1, mk("m_vec_we",  0, 0,       0, 0,       0, 1, 1, 0, 0, 32'h600, 32'h20C, 1, 0, 2));

    step(1, mk("t_isr_we",  0, 0,       0, 0,       0, 1, 1, 0, 0, 32'h600, 32'h20C, 1, 1, 2));
    step(1, mk("t_nonest",  1, 32'h700, 1, 32'h300, 0, 0, 0, 0, 0, 32'h600, 32'h20C, 1, 1, 2));
    step(1, mk("t_mret",    1, 32'h700, 1, 32'h999, 1, 0, 0, 0, 1, 32'h20C, 32'h20C, 1, 1, 2));
    step(1, mk("t_return",  1, 32'h700, 1, 32'h210, 0, 0, 0, 0, 0, 32'h20C, 32'h20C, 0, 1, 2));
    step(1, mk("t_chain",   1, 32'h700, 1, 32'h214, 0, 0, 0, 1, 0, 32'h20C, 32'h214, 0, 1, 2));
    step(1, mk("t_redir",   0, 0,       0, 0,       0, 0, 0, 0, 1, 32'h700, 32'h214, 0, 1, 2));
    step(1, mk("t_vector",  0, 0,       0, 0,       0, 0, 0, 0, 0, 32'h700, 32'h214, 1, 0, 3));

    // IACK_CYCLES=3, CNT_W=2: pulse width, vector capture, same-cycle enable write, saturation
    do_reset(3, 1'b1);
    step(3, mk("p3_take",   1, 32'h200, 1, 32'h104, 0, 1, 0, 1, 0, 0,       32'h104, 0, 0, 0));
    step(3, mk("p3_ack1",   0, 32'h300, 0, 0,       0, 0, 0, 1, 0, 0,       32'h104, 0, 0, 0));
    step(3, mk("p3_ack2",   0, 32'h300, 0, 0,       0, 0, 0, 1, 0, 0,       32'h104, 0, 0, 0));
    step(3, mk("p3_redir",  0, 32'h300, 0, 0,       0, 0, 0, 0, 1, 32'h200, 32'h104, 0, 0, 0));
    step(3, mk("p3_vector", 0, 0,       0, 0,       0, 0, 0, 0, 0, 32'h200, 32'h104, 1, 0, 1));
    step(3, mk("p3_mret",   0, 0,       1, 0,       1, 0, 0, 0, 1, 32'h104, 32'h104, 1, 0, 1));
    step(3, mk("p3_return", 0, 0,       0, 0,       0, 0, 0, 0, 0, 32'h104, 32'h104, 0, 1, 1));
    pra = 32'h104;
    for (int k = 2; k <= 5; k++) begin
      pc = 32'(32'h1000 + k * 4);
      a  = 32'(32'h2000 + k * 16);
      cp = (k - 1 > 3) ? 16'd3 : 16'(k - 1);
      c  = (k > 3) ? 16'd3 : 16'(k);
      step(3, mk("s_take",   1, a, 1, pc, 0, 0, 0, 1, 0, pra, pc, 0, 1, cp));
      step(3, mk("s_ack1",   0, 0, 0, 0,  0, 0, 0, 1, 0, pra, pc, 0, 1, cp));
      step(3, mk("s_ack2",   0, 0, 0, 0,  0, 0, 0, 1, 0, pra, pc, 0, 1, cp));
      step(3, mk("s_redir",  0, 0, 0, 0,  0, 0, 0, 0, 1, a,   pc, 0, 1, cp));
      step(3, mk("s_count",  0, 0, 0, 0,  0, 0, 0, 0, 0, a,   pc, 1, 0, c));
      step(3, mk("s_mret",   0, 0, 1, 0,  1, 0, 0, 0, 1, pc,  pc, 1, 0, c));
      step(3, mk("s_return", 0, 0, 0, 0,  0, 0, 0, 0, 0, pc,  pc, 0, 1, c));
      pra = pc;
    end

    // IACK_CYCLES=4, EN_RESET=0: asynchronous reset in the second iack cycle
    do_reset(4, 1'b0);
    step(4, mk("r_enable", 0, 0,      0, 0,     0, 1, 1, 0, 0, 0, 0,     0, 1, 0));
    step(4, mk("r_take",   1, 32'h80, 1, 32'h40, 0, 0, 0, 1, 0, 0, 32'h40, 0, 1, 0));
    step(4, mk("r_ack1",   1, 32'h80, 0, 0,     0, 0, 0, 1, 0, 0, 32'h40, 0, 1, 0));
    #2;
    rst = 1'b0;
    #1;
    check(4, mk("r_async", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b1;
    step(4, mk("r_after",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/intc_cpu_responder.md
Name: intc_cpu_responder

Overview:
- CPU-side responder for the interrupt controller's IRQ/IACK/isr_addr handshake.
- Waits for an instruction boundary when IRQ is pending and interrupts are enabled, then pulses IACK and captures the ISR vector.
- Saves the return PC, redirects fetch to the ISR, and restores the PC on mret.
- Sits between the interrupt controller and the core's PC/fetch logic; one clock domain.

Parameters:
- IACK_CYCLES, 1, width of the IACK pulse in clocks (1..15).
- EN_RESET, 1'b1, reset value of int_enable.
- CNT_W, 16, width of the saturating taken-interrupt counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- irq  input  1  interrupt request from controller; level, held until IACK.
- isr_addr  input  32  ISR vector from controller; valid while irq=1.
- instr_retire  input  1  an instruction retires this cycle (instruction boundary).
- pc_next  input  32  address of the instruction following the retiring one.
- mret  input  1  retiring instruction is mret; qualified by instr_retire.
- en_we  input  1  write strobe for int_enable.
- en_wdata  input  1  new int_enable value.
- iack  output  1  interrupt acknowledge to the controller.
- pc_redirect  output  1  one-cycle fetch redirect strobe.
- redirect_addr  output  32  redirect target; valid when pc_redirect=1.
- epc  output  32  saved return PC.
- in_isr  output  1  an ISR is executing.
- int_enable  output  1  global interrupt enable.
- irq_count  output  CNT_W  number of interrupts taken; saturating.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; iack=0, pc_redirect=0, redirect_addr=0, epc=0, in_isr=0, irq_count=0.
  - int_enable=EN_RESET; internal vector register=0; pulse counter=0.
- All outputs are registered.
- States:
  - IDLE -> ACK when irq & int_enable & instr_retire & !mret. At that edge: epc<=pc_next, vector<=isr_addr, iack<=1, pulse counter<=IACK_CYCLES-1.
  - ACK: iack held for IACK_CYCLES cycles total, then iack<=0, pc_redirect<=1, redirect_addr<=vector, go to VECTOR.
  - VECTOR: single cycle. pc_redirect<=0, in_isr<=1, int_enable<=0, irq_count increments (saturates at all-ones), go to IN_ISR.
  - IN_ISR -> RETURN on instr_retire & mret. At that edge: pc_redirect<=1, redirect_addr<=epc.
  - RETURN: single cycle. pc_redirect<=0, in_isr<=0, int_enable<=1, go to IDLE.
- Latency:
  - Boundary cycle to iack rise: 1 clk.
  - Boundary cycle to pc_redirect: IACK_CYCLES+1 clks.
- irq low, or int_enable=0, at a boundary: no action. irq is level-sampled only at retire cycles; no latching.
- irq dropping during ACK: the sequence completes with the captured vector; the controller owns any retraction.
- en_we:
  - Updates int_enable on any cycle in IDLE or IN_ISR.
  - Ignored in ACK, VECTOR and RETURN.
  - In IN_ISR, the value is overwritten to 1 at RETURN.
- en_we=1 in the same cycle as a qualifying boundary in IDLE: the interrupt is taken, and the enable write takes effect in that cycle's update. The VECTOR state then forces int_enable=0.
- No nesting: irq is ignored while in_isr=1.
- mret outside IN_ISR: ignored, no redirect.
- irq=1 and mret in the same IN_ISR cycle: the return is taken first. Because irq is still high, the next qualifying retire in IDLE takes it (tail-chain). RETURN itself never takes irq.
- redirect_addr holds its last value when pc_redirect=0.
- rst asserted mid-sequence (including during iack): everything returns to reset values immediately, and iack drops asynchronously.

Test Plan:
- Basic take and return (IACK_CYCLES=1, int_enable=1):
  - Stimulus: irq=1, isr_addr=0x00000200, retire with pc_next=0x00000104.
  - Required: iack=1 for exactly 1 clk; next clk pc_redirect=1, redirect_addr=0x200; epc=0x104; in_isr=1; int_enable=0; irq_count=1.
  - Then mret retire -> pc_redirect=1 with redirect_addr=0x104; next clk in_isr=0, int_enable=1.
- Masking:
  - Write en_wdata=0; hold irq=1 over 10 retires -> iack stays 0, irq_count=0.
  - Write en_wdata=1 -> iack on the first following retire.
- Pulse width: IACK_CYCLES=3 -> iack high exactly 3 clks; pc_redirect rises on the clock after iack falls; vector is the value captured at the boundary even if isr_addr changes to 0x300 during ACK.
- Tail-chain: irq held high through mret -> RETURN redirect to epc, then a second iack on the next retire; irq_count=2. No iack while in_isr=1.
- Reset mid-ACK (IACK_CYCLES=4): drop rst in the 2nd iack cycle -> iack=0 asynchronously, all outputs at reset values, int_enable=EN_RESET.
- Saturation: CNT_W=2, take 5 interrupts -> irq_count reads 3 after the 3rd and stays at 3.
